// File: rtl/fft_mult_pkg.sv
// Shared constants and types for the FFT twiddle multiplier datapath.
// Booth partial-product geometry plus the negate-correction popcount helper.
package fft_mult_pkg;

    localparam int MUL_IN_W = 16;
    localparam int PP_W     = 32;
    localparam int PP_NUM   = 8;
    localparam int CORR_W   = 4;

    typedef logic [PP_W-1:0] pp_word_t;

    function automatic logic [CORR_W-1:0] popcount_neg(input logic [PP_NUM-1:0] v);
        logic [CORR_W-1:0] c;
        c = '0;
        for (int i = 0; i < PP_NUM; i++) begin
            c = c + CORR_W'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/csa_3to2.sv
// 3:2 carry-save compressor: three words in, sum and left-shifted carry out.
// Purely combinational; the carry out of the top bit is discarded (modulo 2^WIDTH).
module csa_3to2 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_c,
    output logic [WIDTH-1:0] o_sum,
    output logic [WIDTH-1:0] o_carry
);

    logic [WIDTH-1:0] w_maj;

    assign w_maj   = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
    assign o_sum   = i_a ^ i_b ^ i_c;
    assign o_carry = {w_maj[WIDTH-2:0], 1'b0};

endmodule

// File: rtl/booth_pp_compress_pipe.sv
// Reduces eight Booth partial products plus negate correction to a 32-bit signed product.
// Latency: 3 cycles (S1 CSA 9->4, S2 CSA 4->2, S3 CPA) with one set per cycle throughput.
// Backpressure: per-stage valid bits, bubbles collapse; in_ready is combinational from v1..v3/out_ready.
module booth_pp_compress_pipe
    import fft_mult_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PP_W-1:0]   pp0,
    input  logic [PP_W-1:0]   pp1,
    input  logic [PP_W-1:0]   pp2,
    input  logic [PP_W-1:0]   pp3,
    input  logic [PP_W-1:0]   pp4,
    input  logic [PP_W-1:0]   pp5,
    input  logic [PP_W-1:0]   pp6,
    input  logic [PP_W-1:0]   pp7,
    input  logic [PP_NUM-1:0] neg,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PP_W-1:0]   product,
    output logic [TAG_W-1:0]  out_tag
);

    pp_word_t w_cw;
    pp_word_t w_l1_s0, w_l1_c0, w_l1_s1, w_l1_c1, w_l1_s2, w_l1_c2;
    pp_word_t w_l2_s0, w_l2_c0, w_l2_s1, w_l2_c1;
    pp_word_t w_s2_s0, w_s2_c0, w_s2_sum, w_s2_carry;

    logic w_s1_ld, w_s2_ld, w_s3_ld;

    logic              r_v1, r_v2, r_v3;
    pp_word_t          r_s1_a, r_s1_b, r_s1_c, r_s1_d;
    logic [TAG_W-1:0]  r_s1_tag;
    pp_word_t          r_s2_sum, r_s2_carry;
    logic [TAG_W-1:0]  r_s2_tag;
    pp_word_t          r_s3_prod;
    logic [TAG_W-1:0]  r_s3_tag;

    // The +1 for every one's-complemented partial product is folded into a single ninth operand.
    assign w_cw = {{(PP_W-CORR_W){1'b0}}, popcount_neg(neg)};

    csa_3to2 #(.WIDTH(PP_W)) u_l1_0 (.i_a(pp0), .i_b(pp1), .i_c(pp2), .o_sum(w_l1_s0), .o_carry(w_l1_c0));
    csa_3to2 #(.WIDTH(PP_W)) u_l1_1 (.i_a(pp3), .i_b(pp4), .i_c(pp5), .o_sum(w_l1_s1), .o_carry(w_l1_c1));
    csa_3to2 #(.WIDTH(PP_W)) u_l1_2 (.i_a(pp6), .i_b(pp7), .i_c(w_cw), .o_sum(w_l1_s2), .o_carry(w_l1_c2));

    csa_3to2 #(.WIDTH(PP_W)) u_l2_0 (.i_a(w_l1_s0), .i_b(w_l1_c0), .i_c(w_l1_s1), .o_sum(w_l2_s0), .o_carry(w_l2_c0));
    csa_3to2 #(.WIDTH(PP_W)) u_l2_1 (.i_a(w_l1_c1), .i_b(w_l1_s2), .i_c(w_l1_c2), .o_sum(w_l2_s1), .o_carry(w_l2_c1));

    csa_3to2 #(.WIDTH(PP_W)) u_s2_0 (.i_a(r_s1_a), .i_b(r_s1_b), .i_c(r_s1_c), .o_sum(w_s2_s0), .o_carry(w_s2_c0));
    csa_3to2 #(.WIDTH(PP_W)) u_s2_1 (.i_a(w_s2_s0), .i_b(w_s2_c0), .i_c(r_s1_d), .o_sum(w_s2_sum), .o_carry(w_s2_carry));

    assign w_s3_ld  = !r_v3 || out_ready;
    assign w_s2_ld  = !r_v2 || w_s3_ld;
    assign w_s1_ld  = !r_v1 || w_s2_ld;
    assign in_ready = w_s1_ld;

    // Valid bits come only from in_valid and each other, never from the data path.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1      <= 1'b0;
            r_v2      <= 1'b0;
            r_v3      <= 1'b0;
            r_s3_prod <= '0;
            r_s3_tag  <= '0;
        end else begin
            if (w_s1_ld) r_v1 <= in_valid;
            if (w_s2_ld) r_v2 <= r_v1;
            if (w_s3_ld) r_v3 <= r_v2;
            if (w_s3_ld && r_v2) begin
                r_s3_prod <= r_s2_sum + r_s2_carry;
                r_s3_tag  <= r_s2_tag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_s1_ld && in_valid) begin
            r_s1_a   <= w_l2_s0;
            r_s1_b   <= w_l2_c0;
            r_s1_c   <= w_l2_s1;
            r_s1_d   <= w_l2_c1;
            r_s1_tag <= in_tag;
        end
        if (w_s2_ld && r_v1) begin
            r_s2_sum   <= w_s2_sum;
            r_s2_carry <= w_s2_carry;
            r_s2_tag   <= r_s1_tag;
        end
    end

    assign out_valid = r_v3;
    assign product   = r_s3_prod;
    assign out_tag   = r_s3_tag;

endmodule

// File: tb/tb_booth_pp_compress_pipe.sv
// Bench: radix-4 Booth encoding of x,y feeds the compressor; a queue of x*y results checks every output.
module tb_booth_pp_compress_pipe;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [7:0][31:0]  pp_bus;
    logic [7:0]        neg;
    logic [3:0]        in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       product;
    logic [3:0]        out_tag;

    typedef struct packed {
        logic [31:0] p;
        logic [3:0]  t;
    } exp_t;

    exp_t               q[$];
    int                 n_tests = 0;
    int                 n_fail  = 0;
    int                 n_out   = 0;
    logic               last_in_fire;
    logic signed [15:0] cur_x, cur_y;
    logic [3:0]         cur_t;

    always #5 clk = ~clk;

    booth_pp_compress_pipe #(.TAG_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pp0       (pp_bus[0]),
        .pp1       (pp_bus[1]),
        .pp2       (pp_bus[2]),
        .pp3       (pp_bus[3]),
        .pp4       (pp_bus[4]),
        .pp5       (pp_bus[5]),
        .pp6       (pp_bus[6]),
        .pp7       (pp_bus[7]),
        .neg       (neg),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .out_tag   (out_tag)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Radix-4 Booth decoder: digit j from y[2j+1], y[2j], y[2j-1].
    function automatic void booth(input logic signed [15:0] x, input logic [15:0] y,
                                  output logic [7:0][31:0] ppv, output logic [7:0] nv);
        logic [31:0] xs, m;
        logic [16:0] ye;
        logic [2:0]  tr;
        logic        n;
        xs = {{16{x[15]}}, x};
        ye = {y, 1'b0};
        for (int j = 0; j < 8; j++) begin
            tr = ye[2*j +: 3];
            case (tr)
                3'b001, 3'b010: begin m = xs;      n = 1'b0; end
                3'b011:         begin m = xs << 1; n = 1'b0; end
                3'b100:         begin m = xs << 1; n = 1'b1; end
                3'b101, 3'b110: begin m = xs;      n = 1'b1; end
                default:        begin m = '0;      n = 1'b0; end
            endcase
            m      = m << (2*j);
            ppv[j] = n ? ~m : m;
            nv[j]  = n;
        end
    endfunction

    task automatic drive(input logic v, input logic signed [15:0] x, input logic signed [15:0] y,
                         input logic [3:0] t);
        logic [7:0][31:0] ppv;
        logic [7:0]       nv;
        booth(x, y, ppv, nv);
        in_valid = v;
        cur_x = x;
        cur_y = y;
        cur_t = t;
        if (v) begin
            pp_bus = ppv;
            neg    = nv;
            in_tag = t;
        end else begin
            pp_bus = 'x;
            neg    = 'x;
            in_tag = 'x;
        end
    endtask

    // One clock: judge the handshakes mid-cycle, score them, then advance past the next edge.
    task automatic step();
        logic        in_fire, out_fire;
        exp_t        e;
        logic signed [31:0] px;
        @(negedge clk);
        in_fire  = in_valid && in_ready;
        out_fire = out_valid && out_ready;
        last_in_fire = in_fire && !rst;
        if (out_fire) begin
            n_out++;
            if (q.size() == 0) begin
                chk("out_spurious", 32'(out_fire), 32'd0);
            end else begin
                e = q.pop_front();
                chk("out_product", product, e.p);
                chk("out_tag", 32'(out_tag), 32'(e.t));
            end
        end
        if (rst) begin
            q.delete();
        end else if (in_fire) begin
            px  = cur_x * cur_y;
            e.p = px;
            e.t = cur_t;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_one(input logic signed [15:0] x, input logic signed [15:0] y,
                           input logic [3:0] t, input logic [31:0] exp_p);
        out_ready = 1'b1;
        drive(1'b1, x, y, t);
        step();
        chk("one_accepted", 32'(last_in_fire), 32'd1);
        drive(1'b0, 16'sd0, 16'sd0, 4'd0);
        chk("lat_cycle1_valid", 32'(out_valid), 32'd0);
        step();
        chk("lat_cycle2_valid", 32'(out_valid), 32'd0);
        step();
        chk("lat_cycle3_valid", 32'(out_valid), 32'd1);
        chk("lat_cycle3_product", product, exp_p);
        chk("lat_cycle3_tag", 32'(out_tag), 32'(t));
        step();
    endtask

    task automatic drain();
        out_ready = 1'b1;
        drive(1'b0, 16'sd0, 16'sd0, 4'd0);
        for (int i = 0; i < 10 && q.size() != 0; i++) step();
        chk("drain_empty", 32'(q.size()), 32'd0);
    endtask

    initial begin
        int idx, cyc, acc, outs0;
        logic pend;
        logic [31:0] r;

        rst = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, 16'sd0, 16'sd0, 4'd0);
        step();
        step();
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_product", product, 32'd0);
        chk("reset_out_tag", 32'(out_tag), 32'd0);
        rst = 1'b0;
        chk("reset_in_ready", 32'(in_ready), 32'd1);

        run_one(16'sd3, 16'sd5, 4'd1, 32'h0000000F);
        run_one(-16'sd32768, -16'sd32768, 4'd2, 32'h40000000);
        run_one(-16'sd1, 16'sd1, 4'd3, 32'hFFFFFFFF);
        run_one(16'sd0, -16'sd7, 4'd4, 32'h00000000);

        // Back-to-back stream with the consumer stalled for cycles 2..8.
        idx = 0;
        cyc = 0;
        while ((idx < 10 || q.size() != 0) && cyc < 200) begin
            out_ready = !(cyc >= 2 && cyc <= 8);
            if (idx < 10) drive(1'b1, 16'(idx*1234 - 5000), 16'(300 - idx*77), 4'(idx));
            else          drive(1'b0, 16'sd0, 16'sd0, 4'd0);
            if (cyc >= 3 && cyc <= 8) chk("stall_in_ready", 32'(in_ready), 32'd0);
            if (cyc == 4 || cyc == 8) begin
                chk("stall_out_valid", 32'(out_valid), 32'd1);
                chk("stall_product", product, q[0].p);
                chk("stall_tag", 32'(out_tag), 32'(q[0].t));
            end
            step();
            if (last_in_fire) idx++;
            cyc++;
        end
        chk("stall_all_delivered", 32'(idx == 10 && q.size() == 0), 32'd1);

        // Consumer ready toggling every cycle.
        idx = 0;
        cyc = 0;
        outs0 = n_out;
        while ((idx < 20 || q.size() != 0) && cyc < 400) begin
            out_ready = cyc[0];
            if (idx < 20) drive(1'b1, 16'(idx*-911 + 77), 16'(idx*1500 - 14000), 4'(idx + 3));
            else          drive(1'b0, 16'sd0, 16'sd0, 4'd0);
            step();
            if (last_in_fire) idx++;
            cyc++;
        end
        chk("toggle_count", 32'(n_out - outs0), 32'd20);
        chk("toggle_queue_empty", 32'(q.size()), 32'd0);

        // Reset with three sets in flight.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'(1000 + i), 16'(-2000 - i), 4'(9 + i));
            step();
        end
        chk("rst_pipe_full", 32'(in_ready), 32'd0);
        drive(1'b0, 16'sd0, 16'sd0, 4'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rst_no_ghost", 32'(out_valid), 32'd0);
        end
        run_one(16'sd2, -16'sd3, 4'd5, 32'hFFFFFFFA);

        // Random operands, random offer and consumer readiness.
        acc = 0;
        cyc = 0;
        pend = 1'b0;
        while (acc < 10000 && cyc < 60000) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (!pend) begin
                if ($urandom_range(0, 3) != 0) begin
                    r = $urandom();
                    drive(1'b1, r[15:0], r[31:16], 4'($urandom_range(0, 15)));
                    pend = 1'b1;
                end else begin
                    drive(1'b0, 16'sd0, 16'sd0, 4'd0);
                end
            end
            step();
            if (last_in_fire) begin
                acc++;
                pend = 1'b0;
            end
            cyc++;
        end
        chk("random_all_accepted", 32'(acc), 32'd10000);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
